// File: rtl/hash_des_pkg.sv
// hash_des_pkg: shared types and constants for the streaming DES-style hash.
//   nib_t   - 4-bit nibble
//   SBOX    - PRESENT 4-bit substitution box
//   IV8     - 8-entry initial-value pattern, h0 first; repeated for wider digests
//   state_t - control FSM states
package hash_des_pkg;

  typedef logic [3:0] nib_t;

  localparam nib_t SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam nib_t IV8 [8] = '{
    4'h4, 4'hB, 4'h7, 4'h1, 4'hD, 4'hF, 4'h0, 4'h3
  };

  typedef enum logic [1:0] {IDLE, ABSORB, ROUND, FINAL} state_t;

  function automatic nib_t sbox(input nib_t x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/hash_des_round.sv
// hash_des_round: one combinational substitution round.
//   h      - current state, nibble i at h[4i+3:4i]
//   m4     - compressed message nibble
//   j      - round index
//   h_next - S[h[(i+1) mod N_NIB] ^ m4 ^ j] for every nibble i
module hash_des_round
  import hash_des_pkg::*;
#(
  parameter int N_NIB = 8
) (
  input  logic [4*N_NIB-1:0] h,
  input  logic [3:0]         m4,
  input  logic [3:0]         j,
  output logic [4*N_NIB-1:0] h_next
);

  always_comb begin
    h_next = '0;
    for (int unsigned i = 0; i < N_NIB; i++) begin
      h_next[4*i +: 4] = sbox(h[4*((i + 1) % N_NIB) +: 4] ^ m4 ^ j);
    end
  end

endmodule

// File: rtl/hash_des_stream.sv
// hash_des_stream: streaming nibble-substitution hash with length finalisation.
// Optional feature macro: HASH_LEN_CHECK_EN (adds in_last / len_err).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, msg_len    - begin a message of msg_len bytes (only when !busy)
//   in_valid/in_ready - byte handshake; in_ready is registered
//   in_byte           - message byte
//   busy              - accepted start until digest published
//   digest_valid      - level, digest holds final value
//   digest            - {h[N_NIB-1], ..., h[0]}
//   in_last, len_err  - (HASH_LEN_CHECK_EN) end marker and sticky mismatch flag
module hash_des_stream
  import hash_des_pkg::*;
#(
  parameter int N_NIB  = 8,
  parameter int ROUNDS = 4,
  parameter int LEN_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_byte,
  output logic               busy,
  output logic               digest_valid,
  output logic [4*N_NIB-1:0] digest
`ifdef HASH_LEN_CHECK_EN
  ,
  input  logic               in_last,
  output logic               len_err
`endif
);

  localparam int          DW       = 4 * N_NIB;
  localparam int          PADW     = (DW > LEN_W) ? DW : LEN_W;
  localparam int          FULL_NIB = LEN_W / 4;
  localparam logic [3:0]  RND_LAST = 4'(ROUNDS - 1);

  state_t           state, state_n;
  logic [DW-1:0]    h, h_n, h_round, h_fin, h_iv;
  logic [LEN_W-1:0] cnt, cnt_n, cnt_inc, len_q, len_n;
  logic [3:0]       m4, m4_n, rnd, rnd_n;
  logic             pub, pub_n;
  logic             rdy_n, busy_n, dv_n;
  logic [DW-1:0]    dg_n;
  logic [PADW-1:0]  len_pad;
`ifdef HASH_LEN_CHECK_EN
  logic             err_n;
`endif

  hash_des_round #(.N_NIB(N_NIB)) u_round (
    .h      (h),
    .m4     (m4),
    .j      (rnd),
    .h_next (h_round)
  );

  assign cnt_inc = cnt + LEN_W'(1);

  // Finalisation only mixes whole nibbles of len; a trailing partial nibble
  // and positions beyond LEN_W contribute zero.
  always_comb begin
    len_pad = '0;
    len_pad[LEN_W-1:0] = len_q;
    h_fin = '0;
    h_iv  = '0;
    for (int unsigned i = 0; i < N_NIB; i++) begin
      h_iv[4*i +: 4]  = IV8[i % 8];
      h_fin[4*i +: 4] = sbox(h[4*i +: 4] ^
                             ((i < FULL_NIB) ? len_pad[4*i +: 4] : 4'h0));
    end
  end

  // The finalised state is copied to digest one cycle after FINAL, so busy
  // stays high through that publish cycle and start cannot slip in between.
  always_comb begin
    state_n = state;
    h_n     = h;
    cnt_n   = cnt;
    len_n   = len_q;
    m4_n    = m4;
    rnd_n   = rnd;
    pub_n   = pub;
    rdy_n   = 1'b0;
    busy_n  = busy;
    dg_n    = digest;
    dv_n    = digest_valid;
`ifdef HASH_LEN_CHECK_EN
    err_n   = len_err;
`endif
    unique case (state)
      IDLE: begin
        if (pub) begin
          dg_n   = h;
          dv_n   = 1'b1;
          busy_n = 1'b0;
          pub_n  = 1'b0;
        end else if (start && !busy) begin
          h_n    = h_iv;
          cnt_n  = '0;
          len_n  = msg_len;
          dv_n   = 1'b0;
          busy_n = 1'b1;
`ifdef HASH_LEN_CHECK_EN
          err_n  = 1'b0;
`endif
          if (msg_len == '0) begin
            state_n = FINAL;
          end else begin
            state_n = ABSORB;
            rdy_n   = 1'b1;
          end
        end
      end
      ABSORB: begin
        rdy_n = 1'b1;
        if (in_valid) begin
          m4_n    = in_byte[7:4] ^ in_byte[3:0];
          rnd_n   = '0;
          state_n = ROUND;
          rdy_n   = 1'b0;
`ifdef HASH_LEN_CHECK_EN
          if (in_last != (cnt == len_q - LEN_W'(1))) err_n = 1'b1;
`endif
        end
      end
      ROUND: begin
        h_n   = h_round;
        rnd_n = rnd + 4'd1;
        if (rnd == RND_LAST) begin
          cnt_n = cnt_inc;
          if (cnt_inc == len_q) begin
            state_n = FINAL;
          end else begin
            state_n = ABSORB;
            rdy_n   = 1'b1;
          end
        end
      end
      FINAL: begin
        h_n     = h_fin;
        pub_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      h            <= '0;
      cnt          <= '0;
      len_q        <= '0;
      m4           <= '0;
      rnd          <= '0;
      pub          <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
`ifdef HASH_LEN_CHECK_EN
      len_err      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      h            <= h_n;
      cnt          <= cnt_n;
      len_q        <= len_n;
      m4           <= m4_n;
      rnd          <= rnd_n;
      pub          <= pub_n;
      in_ready     <= rdy_n;
      busy         <= busy_n;
      digest       <= dg_n;
      digest_valid <= dv_n;
`ifdef HASH_LEN_CHECK_EN
      len_err      <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_hash_des_stream.sv
module tb_hash_des_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] msg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        busy;
  logic        digest_valid;
  logic [31:0] digest;
`ifdef HASH_LEN_CHECK_EN
  logic        in_last;
  logic        len_err;
`endif

  int total = 0;
  int bad   = 0;

  string MSG = "Messaggio in chiaro di prova";

  hash_des_stream #(.N_NIB(8), .ROUNDS(4), .LEN_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg_len      (msg_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest)
`ifdef HASH_LEN_CHECK_EN
    ,
    .in_last      (in_last),
    .len_err      (len_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sb(input int x);
    case (x & 15)
      0: return 12;  1: return 5;   2: return 6;   3: return 11;
      4: return 9;   5: return 0;   6: return 10;  7: return 13;
      8: return 3;   9: return 14;  10: return 15; 11: return 8;
      12: return 4;  13: return 7;  14: return 1;  default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] model(input string m, input int len);
    int h[8] = '{4, 11, 7, 1, 13, 15, 0, 3};
    int t[8];
    int m4;
    logic [31:0] r;
    for (int b = 0; b < len; b++) begin
      m4 = (int'(m[b]) >> 4) ^ (int'(m[b]) & 15);
      for (int j = 0; j < 4; j++) begin
        for (int i = 0; i < 8; i++) t[i] = sb(h[(i + 1) % 8] ^ m4 ^ j);
        h = t;
      end
    end
    for (int i = 0; i < 8; i++) h[i] = sb(h[i] ^ ((len >> (4 * i)) & 15));
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(h[i]);
    return r;
  endfunction

  // Drives one message; edge 0 is the edge that samples start.
  task automatic run_msg(input string m, input int len, input bit gaps,
                         input int poke_at, input int last_at, input int abort_after,
                         output int dv_edge, output int rdy_cycles, output bit rdy_iso,
                         output int busy_cycles, output int first_err_idx);
    int idx;
    bit prev_rdy;
    bit acc;
    start = 1'b1; msg_len = 64'(len); in_valid = 1'b0;
    tick;
    start = 1'b0;
    idx = 0; dv_edge = -1; rdy_cycles = 0; rdy_iso = 1'b1;
    busy_cycles = 0; prev_rdy = 1'b0; first_err_idx = -1;
    for (int e = 0; e < 600; e++) begin
      if (digest_valid) begin dv_edge = e; break; end
      if (abort_after >= 0 && idx == abort_after) break;
      if (busy) busy_cycles++;
      if (in_ready) begin
        rdy_cycles++;
        if (prev_rdy) rdy_iso = 1'b0;
      end
      prev_rdy = in_ready;
`ifdef HASH_LEN_CHECK_EN
      if (len_err && first_err_idx < 0) first_err_idx = idx;
      in_last = (idx == last_at);
`endif
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_byte  = (in_ready && in_valid && idx < len) ? m[idx] : 8'(8'hA5 ^ e);
      start    = (e == poke_at);
      msg_len  = (e == poke_at) ? 64'd5 : 64'(len);
      acc      = in_ready && in_valid;
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    start = 1'b0;
`ifdef HASH_LEN_CHECK_EN
    in_last = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", digest_valid); end
    total++; if (digest !== 32'h0) begin bad++; $display("FAIL reset_digest got=%h want=0", digest); end
`ifdef HASH_LEN_CHECK_EN
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err got=%b want=0", len_err); end
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_empty;
    int dv_e, rc, bc, fe; bit iso;
    run_msg("", 0, 1'b0, -1, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e !== 2) begin bad++; $display("FAIL empty_dv_edge got=%0d want=2", dv_e); end
    total++; if (bc !== 2) begin bad++; $display("FAIL empty_busy_cycles got=%0d want=2", bc); end
    total++; if (digest !== 32'hBC275D89) begin bad++; $display("FAIL empty_digest got=%h want=BC275D89", digest); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy_low got=%b want=0", busy); end
  endtask

  task automatic test_one_byte;
    int dv_e, rc, bc, fe; bit iso;
    string z = "\000";
    run_msg(z, 1, 1'b0, -1, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e !== 7) begin bad++; $display("FAIL byte00_dv_edge got=%0d want=7", dv_e); end
    total++; if (digest !== 32'h317FE8D7) begin bad++; $display("FAIL byte00_digest got=%h want=317FE8D7", digest); end
  endtask

  task automatic test_stream;
    int dv_e, rc, bc, fe; bit iso;
    logic [31:0] exp = model(MSG, 28);
    run_msg(MSG, 28, 1'b0, -1, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e !== 142) begin bad++; $display("FAIL stream_dv_edge got=%0d want=142", dv_e); end
    total++; if (digest !== exp) begin bad++; $display("FAIL stream_digest got=%h want=%h", digest, exp); end
    total++; if (rc !== 28) begin bad++; $display("FAIL stream_ready_cycles got=%0d want=28", rc); end
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL stream_ready_isolated got=%b want=1", iso); end
  endtask

  task automatic test_gaps;
    int dv_e, rc, bc, fe; bit iso;
    logic [31:0] exp = model(MSG, 28);
    run_msg(MSG, 28, 1'b1, -1, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e < 142) begin bad++; $display("FAIL gaps_dv_edge got=%0d want>=142", dv_e); end
    total++; if (digest !== exp) begin bad++; $display("FAIL gaps_digest got=%h want=%h", digest, exp); end
  endtask

  task automatic test_reset_mid;
    int dv_e, rc, bc, fe; bit iso;
    logic [31:0] exp = model(MSG, 28);
    run_msg(MSG, 28, 1'b0, -1, -1, 10, dv_e, rc, iso, bc, fe);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if ({in_ready, busy, digest_valid} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b want=000", {in_ready, busy, digest_valid}); end
    total++; if (digest !== 32'h0) begin bad++; $display("FAIL midrst_digest got=%h want=0", digest); end
    run_msg(MSG, 28, 1'b0, -1, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e !== 142) begin bad++; $display("FAIL midrst_dv_edge got=%0d want=142", dv_e); end
    total++; if (digest !== exp) begin bad++; $display("FAIL midrst_digest_after got=%h want=%h", digest, exp); end
  endtask

  task automatic test_start_busy;
    int dv_e, rc, bc, fe; bit iso;
    logic [31:0] exp = model(MSG, 28);
    run_msg(MSG, 28, 1'b0, 20, -1, -1, dv_e, rc, iso, bc, fe);
    total++; if (dv_e !== 142) begin bad++; $display("FAIL busy_start_dv_edge got=%0d want=142", dv_e); end
    total++; if (digest !== exp) begin bad++; $display("FAIL busy_start_digest got=%h want=%h", digest, exp); end
  endtask

  task automatic test_hold_restart;
    logic [31:0] exp = model(MSG, 28);
    tick; tick; tick;
    total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL hold_dv got=%b want=1", digest_valid); end
    total++; if (digest !== exp) begin bad++; $display("FAIL hold_digest got=%h want=%h", digest, exp); end
    start = 1'b1; msg_len = 64'd1;
    tick;
    start = 1'b0;
    total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL restart_dv got=%b want=0", digest_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

`ifdef HASH_LEN_CHECK_EN
  task automatic test_len_err;
    int dv_e, rc, bc, fe; bit iso;
    logic [31:0] exp = model("abc", 3);
    run_msg("abc", 3, 1'b0, -1, 1, -1, dv_e, rc, iso, bc, fe);
    total++; if (fe !== 2) begin bad++; $display("FAIL len_err_first_idx got=%0d want=2", fe); end
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len_err_sticky got=%b want=1", len_err); end
    total++; if (digest !== exp) begin bad++; $display("FAIL len_err_digest got=%h want=%h", digest, exp); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; msg_len = '0; in_valid = 1'b0; in_byte = '0;
`ifdef HASH_LEN_CHECK_EN
    in_last = 1'b0;
`endif
    tick; tick;
    test_reset;
    test_empty;
    test_one_byte;
    test_stream;
    test_gaps;
    test_reset_mid;
    test_start_busy;
    test_hold_restart;
`ifdef HASH_LEN_CHECK_EN
    test_len_err;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
